val2_shift_arbiter: RTL and testbench
=====================================

Name: val2_shift_arbiter

Overview:
- Shares one Val2 operand shifter between two requesters: req0 (EXE data-processing operand) and req1 (MEM load/store offset).
- Arbitrates requests, then sequences single-cycle immediate shifts and two-cycle register-specified shifts.
- Returns the result with the ARM shifter carry-out over a valid/ready handshake.
- Sits between the ID/EXE pipeline registers and the ALU/address adder.

Parameters:
- FIXED_PRIO, 0, 1 = req0 always wins; 0 = round-robin between req0 and req1.
- TAG_W, 4, width of the opaque tag carried from request to result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_flag  in  1  current CPSR C flag; used for RRX and for zero-amount carry.
- reqN_valid  in  1  request valid (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle when valid && ready.
- reqN_imm  in  1  I bit: 32-bit rotated immediate.
- reqN_bypass  in  1  12-bit offset passes through zero-extended.
- reqN_rm  in  32  Rm value.
- reqN_rs  in  8  Rs[7:0]; used only when shift_operand[4]=1 and imm=0.
- reqN_shift_operand  in  12  instruction bits [11:0].
- reqN_tag  in  TAG_W  requester tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_val2  out  32  shifted operand.
- out_carry  out  1  shifter carry-out.
- out_src  out  1  winning requester index.
- out_tag  out  TAG_W  tag of the winning request.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; out_valid=0; out_val2=0; out_carry=0; out_src=0; out_tag=0.
  - Round-robin pointer = req0; both reqN_ready=0 while reset is asserted.
- States and transitions:
  - IDLE: reqN_ready is driven for the arbitration winner only. On accept, latch the request. Go to RS_WAIT if it is a register shift, otherwise go to DONE with the result computed.
  - RS_WAIT: one cycle. Compute using the latched rs, then go to DONE.
  - DONE: out_valid=1; outputs are stable until out_ready.
    - If out_ready and a request is pending, accept the new winner the same cycle (back-to-back).
    - If out_ready and nothing is pending, go to IDLE.
- Latency: result valid 1 cycle after accept for immediate, imm-shift and bypass requests; 2 cycles after accept for register shifts. Throughput is 1 result per cycle when out_ready is held high.
- Arbitration:
  - Round-robin: pointer toggles to the other requester after each grant.
  - On simultaneous requests, the pointer's requester wins.
  - The loser's ready stays 0; it must hold valid and payload stable.
- Precedence: bypass > imm > register-shift > immediate-shift.
  - bypass: val2 = {20'b0, shift_operand}; carry = c_flag.
  - imm: val2 = ror({24'b0, so[7:0]}, 2*so[11:8]). carry = val2[31] if rotate≠0, else c_flag.
  - imm-shift, amount = so[11:7], type = so[6:5]:
    - LSL #0: val2 = Rm; carry = c.
    - LSR #0: treated as #32; val2 = 0; carry = Rm[31].
    - ASR #0: treated as #32; all bits = Rm[31]; carry = Rm[31].
    - ROR #0: RRX; val2 = {c, Rm[31:1]}; carry = Rm[0].
  - register-shift, amount = rs[7:0]:
    - amount 0: val2 = Rm; carry = c.
    - LSL 32: val2 = 0; carry = Rm[0]. LSL >32: val2 = 0; carry = 0.
    - LSR 32: val2 = 0; carry = Rm[31]. LSR >32: val2 = 0; carry = 0.
    - ASR ≥32: all bits = Rm[31]; carry = Rm[31].
    - ROR: rotate by amount[4:0]. If amount[4:0]=0 and amount≠0: val2 = Rm; carry = Rm[31].
- c_flag is sampled at accept, not at compute.
- Reset mid-operation discards any in-flight or held result; no output is produced for it.

Optional Feature:
- Macro: VAL2_ARB_STATS_EN.
- When defined:
  - Adds ports stat_grant0, stat_grant1, stat_stall (each 16-bit out).
  - Saturating counters: grants per requester, and cycles with out_valid && !out_ready.
  - Counters clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package val2_pkg:
  - Shift-type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11.
  - State enum IDLE/RS_WAIT/DONE.
- Sub-module val2_shift_core: purely combinational. Inputs are imm, bypass, reg_shift, rm, amount, so, c_in; outputs are val2 and carry. It holds all the shift rules above; the arbiter owns the FSM and handshake.

Test Plan:
- req0 imm-shift LSL #4 (so=12'h200), Rm=0x000000F1, c=0 → val2 0x00000F10, carry 0, 1 cycle after accept.
- req1 imm (so=12'h4FF), c=0 → val2 0xFF000000, carry 1; bypass so=12'hABC, c=1 → val2 0x00000ABC, carry 1.
- Register LSR, Rm=0x80000000:
  - rs=32 → val2 0, carry 1, 2 cycles after accept.
  - rs=33 → val2 0, carry 0.
  - rs=0 → val2 0x80000000, carry = c.
- ROR #0 (RRX), Rm=0x00000003, c=1 → val2 0x80000001, carry 1.
- Both requesters held valid for 4 grants, out_ready=1, FIXED_PRIO=0 → out_src sequence 0,1,0,1; one result per cycle; tags match.
- out_ready low for 3 cycles in DONE → outputs stable, both readies 0. Then assert rst mid-hold → out_valid 0 immediately, next grant goes to req0.

Source files
------------

// File: rtl/val2_pkg.sv
// -----------------------------------------------------------------------------
// val2_pkg
// Shared definitions for the Val2 operand shifter and its two-port arbiter.
//   - Shift-type encodings as they appear in instruction bits [6:5]
//   - Arbiter state encoding
//   - ror32 helper used by both the rotated-immediate and ROR paths
// -----------------------------------------------------------------------------
package val2_pkg;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RS_WAIT = 2'b01,
        DONE    = 2'b10
    } state_t;

    // Rotate right by 0..31; doubling the word avoids a 32-bit shift by 32.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] w;
        w = {x, x} >> amt;
        return w[31:0];
    endfunction

endpackage

// File: rtl/val2_shift_core.sv
// -----------------------------------------------------------------------------
// val2_shift_core
// Purely combinational ARM Val2 operand generator with shifter carry-out.
// Precedence: bypass > rotated immediate > register shift > immediate shift.
// Ports:
//   i_imm        I bit: 32-bit rotated immediate from so[11:0]
//   i_bypass     12-bit offset passed through zero-extended
//   i_reg_shift  shift amount comes from i_amount (Rs[7:0]) instead of so[11:7]
//   i_rm         Rm operand
//   i_amount     shift amount (Rs[7:0], or so[11:7] zero-extended)
//   i_so         instruction bits [11:0]
//   i_c_in       C flag sampled when the request was accepted
//   o_val2       shifted operand
//   o_carry      shifter carry-out
// -----------------------------------------------------------------------------
module val2_shift_core
    import val2_pkg::*;
(
    input  logic        i_imm,
    input  logic        i_bypass,
    input  logic        i_reg_shift,
    input  logic [31:0] i_rm,
    input  logic [7:0]  i_amount,
    input  logic [11:0] i_so,
    input  logic        i_c_in,
    output logic [31:0] o_val2,
    output logic        o_carry
);

    logic [1:0]         w_type;
    logic               w_rrx;
    logic [7:0]         w_eff_amt;
    logic [31:0]        w_imm_val;
    logic [32:0]        w_lsl;
    logic [32:0]        w_lsr;
    logic signed [32:0] w_asr_src;
    logic signed [32:0] w_asr;
    logic [31:0]        w_ror;

    assign w_type = i_so[6:5];

    // Immediate ROR #0 is really RRX; register shifts never take this path.
    assign w_rrx = !i_reg_shift && (w_type == ROR) && (i_amount[4:0] == 5'd0);

    // Immediate LSR/ASR #0 encode a shift by 32.
    always_comb begin
        w_eff_amt = {3'b000, i_amount[4:0]};
        if (i_reg_shift) begin
            w_eff_amt = i_amount;
        end else if ((i_amount[4:0] == 5'd0) && ((w_type == LSR) || (w_type == ASR))) begin
            w_eff_amt = 8'd32;
        end
    end

    assign w_imm_val = ror32({24'h000000, i_so[7:0]}, {i_so[11:8], 1'b0});

    // The extra 33rd bit catches the last bit shifted out, so amounts of 32 and
    // above fall out of the same expression with the correct carry.
    assign w_lsl     = {1'b0, i_rm} << w_eff_amt;
    assign w_lsr     = {i_rm, 1'b0} >> w_eff_amt;
    assign w_asr_src = $signed({i_rm, 1'b0});
    assign w_asr     = w_asr_src >>> w_eff_amt;
    assign w_ror     = ror32(i_rm, w_eff_amt[4:0]);

    always_comb begin
        o_val2  = i_rm;
        o_carry = i_c_in;
        if (i_bypass) begin
            o_val2  = {20'h00000, i_so};
            o_carry = i_c_in;
        end else if (i_imm) begin
            o_val2  = w_imm_val;
            o_carry = (i_so[11:8] != 4'd0) ? w_imm_val[31] : i_c_in;
        end else if (w_rrx) begin
            o_val2  = {i_c_in, i_rm[31:1]};
            o_carry = i_rm[0];
        end else if (w_eff_amt != 8'd0) begin
            case (w_type)
                LSL: begin
                    o_val2  = w_lsl[31:0];
                    o_carry = w_lsl[32];
                end
                LSR: begin
                    o_val2  = w_lsr[32:1];
                    o_carry = w_lsr[0];
                end
                ASR: begin
                    o_val2  = w_asr[32:1];
                    o_carry = w_asr[0];
                end
                default: begin
                    // A non-zero multiple of 32 leaves Rm unchanged with carry = Rm[31].
                    o_val2  = w_ror;
                    o_carry = w_ror[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_shift_arbiter.sv
// -----------------------------------------------------------------------------
// val2_shift_arbiter
// Shares one val2_shift_core between req0 (EXE operand) and req1 (MEM offset).
// Immediate, imm-shift and bypass requests produce a result one cycle after
// accept; register-specified shifts take two. Results are held on a
// valid/ready output until consumed; a new winner can be accepted in the same
// cycle the previous result is consumed.
// Parameters:
//   FIXED_PRIO  1 = req0 always wins, 0 = round-robin
//   TAG_W       width of the opaque tag carried from request to result
// Ports:
//   clk, rst (async, active-low), c_flag
//   reqN_valid/ready/imm/bypass/rm/rs/shift_operand/tag  (N = 0, 1)
//   out_valid/ready/val2/carry/src/tag
// Optional build macro VAL2_ARB_STATS_EN adds saturating counters
//   stat_grant0, stat_grant1 (grants per requester) and stat_stall
//   (cycles with out_valid && !out_ready).
// -----------------------------------------------------------------------------
module val2_shift_arbiter
    import val2_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_flag,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_imm,
    input  logic             req0_bypass,
    input  logic [31:0]      req0_rm,
    input  logic [7:0]       req0_rs,
    input  logic [11:0]      req0_shift_operand,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_imm,
    input  logic             req1_bypass,
    input  logic [31:0]      req1_rm,
    input  logic [7:0]       req1_rs,
    input  logic [11:0]      req1_shift_operand,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_val2,
    output logic             out_carry,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
`ifdef VAL2_ARB_STATS_EN
    ,
    output logic [15:0]      stat_grant0,
    output logic [15:0]      stat_grant1,
    output logic [15:0]      stat_stall
`endif
);

    state_t     r_state;
    logic       r_rr_ptr;
    logic [31:0] r_rm;
    logic [7:0]  r_rs;
    logic [11:0] r_so;
    logic        r_c;

    logic             w_can_accept;
    logic             w_winner;
    logic             w_accept;
    logic             w_sel_imm;
    logic             w_sel_bypass;
    logic [31:0]      w_sel_rm;
    logic [7:0]       w_sel_rs;
    logic [11:0]      w_sel_so;
    logic [TAG_W-1:0] w_sel_tag;
    logic             w_sel_reg;

    logic             w_core_imm;
    logic             w_core_bypass;
    logic             w_core_reg;
    logic [31:0]      w_core_rm;
    logic [7:0]       w_core_amount;
    logic [11:0]      w_core_so;
    logic             w_core_c;
    logic [31:0]      w_core_val2;
    logic             w_core_carry;

    // A new request can enter from IDLE, or from DONE in the cycle the held
    // result is consumed.
    assign w_can_accept = (r_state == IDLE) || ((r_state == DONE) && out_ready);

    // Winner selection; the pointer only matters when both requesters are valid.
    always_comb begin
        w_winner = 1'b0;
        if (FIXED_PRIO != 0) begin
            w_winner = !req0_valid;
        end else if (req0_valid && req1_valid) begin
            w_winner = r_rr_ptr;
        end else begin
            w_winner = req1_valid;
        end
    end

    // Readies are forced low while reset is asserted, independent of state.
    assign req0_ready = rst && w_can_accept && req0_valid && (w_winner == 1'b0);
    assign req1_ready = rst && w_can_accept && req1_valid && (w_winner == 1'b1);
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_imm    = w_winner ? req1_imm           : req0_imm;
    assign w_sel_bypass = w_winner ? req1_bypass        : req0_bypass;
    assign w_sel_rm     = w_winner ? req1_rm            : req0_rm;
    assign w_sel_rs     = w_winner ? req1_rs            : req0_rs;
    assign w_sel_so     = w_winner ? req1_shift_operand : req0_shift_operand;
    assign w_sel_tag    = w_winner ? req1_tag           : req0_tag;
    assign w_sel_reg    = !w_sel_bypass && !w_sel_imm && w_sel_so[4];

    // In RS_WAIT the core sees the latched register-shift request; otherwise
    // it evaluates the current winner so the result is ready at accept.
    always_comb begin
        if (r_state == RS_WAIT) begin
            w_core_imm    = 1'b0;
            w_core_bypass = 1'b0;
            w_core_reg    = 1'b1;
            w_core_rm     = r_rm;
            w_core_amount = r_rs;
            w_core_so     = r_so;
            w_core_c      = r_c;
        end else begin
            w_core_imm    = w_sel_imm;
            w_core_bypass = w_sel_bypass;
            w_core_reg    = w_sel_reg;
            w_core_rm     = w_sel_rm;
            w_core_amount = w_sel_reg ? w_sel_rs : {3'b000, w_sel_so[11:7]};
            w_core_so     = w_sel_so;
            w_core_c      = c_flag;
        end
    end

    val2_shift_core u_core (
        .i_imm       (w_core_imm),
        .i_bypass    (w_core_bypass),
        .i_reg_shift (w_core_reg),
        .i_rm        (w_core_rm),
        .i_amount    (w_core_amount),
        .i_so        (w_core_so),
        .i_c_in      (w_core_c),
        .o_val2      (w_core_val2),
        .o_carry     (w_core_carry)
    );

    assign out_valid = (r_state == DONE);

    // FSM, result registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= 1'b0;
            r_rm      <= '0;
            r_rs      <= '0;
            r_so      <= '0;
            r_c       <= 1'b0;
            out_val2  <= '0;
            out_carry <= 1'b0;
            out_src   <= 1'b0;
            out_tag   <= '0;
        end else begin
            case (r_state)
                RS_WAIT: begin
                    out_val2  <= w_core_val2;
                    out_carry <= w_core_carry;
                    r_state   <= DONE;
                end
                default: begin
                    if (w_accept) begin
                        out_src  <= w_winner;
                        out_tag  <= w_sel_tag;
                        r_rr_ptr <= !w_winner;
                        if (w_sel_reg) begin
                            r_rm    <= w_sel_rm;
                            r_rs    <= w_sel_rs;
                            r_so    <= w_sel_so;
                            r_c     <= c_flag;
                            r_state <= RS_WAIT;
                        end else begin
                            out_val2  <= w_core_val2;
                            out_carry <= w_core_carry;
                            r_state   <= DONE;
                        end
                    end else if ((r_state == DONE) && out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef VAL2_ARB_STATS_EN
    logic [15:0] r_stat_grant0;
    logic [15:0] r_stat_grant1;
    logic [15:0] r_stat_stall;

    // Saturating usage counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_grant0 <= '0;
            r_stat_grant1 <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (req0_ready && (r_stat_grant0 != 16'hFFFF)) begin
                r_stat_grant0 <= r_stat_grant0 + 16'd1;
            end
            if (req1_ready && (r_stat_grant1 != 16'hFFFF)) begin
                r_stat_grant1 <= r_stat_grant1 + 16'd1;
            end
            if (out_valid && !out_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_grant0 = r_stat_grant0;
    assign stat_grant1 = r_stat_grant1;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_val2_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_val2_shift_arbiter
// Directed bench for val2_shift_arbiter (FIXED_PRIO=0, TAG_W=4): a vector
// table of single requests with hand-computed results and latencies, then
// round-robin back-to-back, output hold and mid-hold reset sequences.
// -----------------------------------------------------------------------------
module tb_val2_shift_arbiter;

    typedef struct {
        logic        useReq1;
        logic        imm;
        logic        bypass;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic [11:0] so;
        logic        cFlag;
        logic [3:0]  tag;
        logic [31:0] expVal2;
        logic        expCarry;
        int          expLatency;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        c_flag;
    logic        req0_valid, req0_ready, req0_imm, req0_bypass;
    logic [31:0] req0_rm;
    logic [7:0]  req0_rs;
    logic [11:0] req0_shift_operand;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_imm, req1_bypass;
    logic [31:0] req1_rm;
    logic [7:0]  req1_rs;
    logic [11:0] req1_shift_operand;
    logic [3:0]  req1_tag;
    logic        out_valid, out_ready, out_carry, out_src;
    logic [31:0] out_val2;
    logic [3:0]  out_tag;
`ifdef VAL2_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_stall;
`endif

    int checkCount = 0;
    int passCount  = 0;
    vec_t vecs[13];

    val2_shift_arbiter #(.FIXED_PRIO(0), .TAG_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .c_flag             (c_flag),
        .req0_valid         (req0_valid),
        .req0_ready         (req0_ready),
        .req0_imm           (req0_imm),
        .req0_bypass        (req0_bypass),
        .req0_rm            (req0_rm),
        .req0_rs            (req0_rs),
        .req0_shift_operand (req0_shift_operand),
        .req0_tag           (req0_tag),
        .req1_valid         (req1_valid),
        .req1_ready         (req1_ready),
        .req1_imm           (req1_imm),
        .req1_bypass        (req1_bypass),
        .req1_rm            (req1_rm),
        .req1_rs            (req1_rs),
        .req1_shift_operand (req1_shift_operand),
        .req1_tag           (req1_tag),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_val2           (out_val2),
        .out_carry          (out_carry),
        .out_src            (out_src),
        .out_tag            (out_tag)
`ifdef VAL2_ARB_STATS_EN
        ,
        .stat_grant0        (stat_grant0),
        .stat_grant1        (stat_grant1),
        .stat_stall         (stat_stall)
`endif
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input logic which, input logic imm, input logic bypass,
                            input logic [31:0] rm, input logic [7:0] rs,
                            input logic [11:0] so, input logic [3:0] tag);
        if (which) begin
            req1_valid = 1'b1; req1_imm = imm; req1_bypass = bypass;
            req1_rm = rm; req1_rs = rs; req1_shift_operand = so; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_imm = imm; req0_bypass = bypass;
            req0_rm = rm; req0_rs = rs; req0_shift_operand = so; req0_tag = tag;
        end
    endtask

    // Issues one vector, waits for its acceptance, then measures latency and
    // checks the result while out_ready is held high.
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   waitCnt;
        int   lat;
        logic rdy;
        v = vecs[idx];
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        c_flag     = v.cFlag;
        driveReq(v.useReq1, v.imm, v.bypass, v.rm, v.rs, v.so, v.tag);
        #1;
        waitCnt = 0;
        rdy = v.useReq1 ? req1_ready : req0_ready;
        while (!rdy && waitCnt < 20) begin
            @(negedge clk);
            #1;
            waitCnt++;
            rdy = v.useReq1 ? req1_ready : req0_ready;
        end
        if (!rdy) begin
            checkOutput($sformatf("vec%0d_accept", idx), 32'(rdy), 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            c_flag     = ~v.cFlag;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.expLatency));
            checkOutput($sformatf("vec%0d_val2", idx), out_val2, v.expVal2);
            checkOutput($sformatf("vec%0d_carry", idx), 32'(out_carry), 32'(v.expCarry));
            checkOutput($sformatf("vec%0d_src", idx), 32'(out_src), 32'(v.useReq1));
            checkOutput($sformatf("vec%0d_tag", idx), 32'(out_tag), 32'(v.tag));
        end
    endtask

    initial begin
        // useReq1 imm byp rm rs so c tag expVal2 expCarry latency
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h000000F1, 8'd0,  12'h200, 1'b0, 4'h1, 32'h00000F10, 1'b0, 1}; // LSL #4
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        8'd0,  12'h4FF, 1'b0, 4'h2, 32'hFF000000, 1'b1, 1}; // imm rot 8
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h12345678, 8'd0,  12'hABC, 1'b1, 4'h3, 32'h00000ABC, 1'b1, 1}; // bypass
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h80000000, 8'd32, 12'h030, 1'b0, 4'h4, 32'h00000000, 1'b1, 2}; // reg LSR 32
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h80000000, 8'd33, 12'h030, 1'b1, 4'h5, 32'h00000000, 1'b0, 2}; // reg LSR 33
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h80000000, 8'd0,  12'h030, 1'b1, 4'h6, 32'h80000000, 1'b1, 2}; // reg LSR 0
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h00000003, 8'd0,  12'h060, 1'b1, 4'h7, 32'h80000001, 1'b1, 1}; // RRX
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h80000000, 8'd0,  12'h020, 1'b0, 4'h8, 32'h00000000, 1'b1, 1}; // LSR #0 = 32
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h80000000, 8'd0,  12'h040, 1'b0, 4'h9, 32'hFFFFFFFF, 1'b1, 1}; // ASR #0 = 32
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00000001, 8'd32, 12'h010, 1'b0, 4'hA, 32'h00000000, 1'b1, 2}; // reg LSL 32
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h80000001, 8'd32, 12'h070, 1'b0, 4'hB, 32'h80000001, 1'b1, 2}; // reg ROR 32
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'd0,  12'h0AB, 1'b1, 4'hC, 32'h000000AB, 1'b1, 1}; // imm rot 0
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 8'd40, 12'h050, 1'b1, 4'hD, 32'h00000000, 1'b0, 2}; // reg ASR 40

        rst = 1'b0;
        c_flag = 1'b0;
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_imm = 1'b0; req0_bypass = 1'b0; req0_rm = '0; req0_rs = '0;
        req0_shift_operand = '0; req0_tag = '0;
        req1_valid = 1'b1; req1_imm = 1'b0; req1_bypass = 1'b0; req1_rm = '0; req1_rs = '0;
        req1_shift_operand = '0; req1_tag = '0;

        // Reset state, with both requesters valid so ready-low is meaningful.
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_val2", out_val2, 32'd0);
        checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
        checkOutput("rst_out_src", 32'(out_src), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(i);
        end

        // Round-robin, back-to-back: re-reset so the pointer starts at req0.
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        c_flag = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 32'h000000F1, 8'd0, 12'h200, 4'h5);
        driveReq(1'b1, 1'b0, 1'b1, 32'h0, 8'd0, 12'h123, 4'hA);
        for (int g = 0; g < 4; g++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("rr%0d_valid", g), 32'(out_valid), 32'd1);
            checkOutput($sformatf("rr%0d_src", g), 32'(out_src), 32'(g % 2));
            checkOutput($sformatf("rr%0d_tag", g), 32'(out_tag), (g % 2 == 0) ? 32'h5 : 32'hA);
            checkOutput($sformatf("rr%0d_val2", g), out_val2, (g % 2 == 0) ? 32'h00000F10 : 32'h00000123);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        // Hold with out_ready low (pointer now at req0), then reset mid-hold.
        out_ready = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 32'h000000F1, 8'd0, 12'h200, 4'h3);
        @(posedge clk);
        @(negedge clk);
        driveReq(1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 12'h0AB, 4'h7);
        driveReq(1'b1, 1'b0, 1'b1, 32'h0, 8'd0, 12'h456, 4'hE);
        for (int h = 0; h < 3; h++) begin
            #1;
            checkOutput($sformatf("hold%0d_valid", h), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold%0d_val2", h), out_val2, 32'h00000F10);
            checkOutput($sformatf("hold%0d_tag", h), 32'(out_tag), 32'h3);
            checkOutput($sformatf("hold%0d_src", h), 32'(out_src), 32'd0);
            checkOutput($sformatf("hold%0d_ready0", h), 32'(req0_ready), 32'd0);
            checkOutput($sformatf("hold%0d_ready1", h), 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("midrst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("postrst_ready0", 32'(req0_ready), 32'd1);
        checkOutput("postrst_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("postrst_valid", 32'(out_valid), 32'd1);
        checkOutput("postrst_src", 32'(out_src), 32'd0);
        checkOutput("postrst_tag", 32'(out_tag), 32'h7);
        checkOutput("postrst_val2", out_val2, 32'h000000AB);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
